// File: rtl/seg_scan_decoder.sv
// Rebuilds four BCD digits from an active-low multiplexed 7-segment scan, one frame at a time.
// Optional blink detection is built when SEG_DECODE_BLINK_EN is defined.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] anode,
  input  logic [6:0] cathode,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [3:0] blank,
  output logic [3:0] blinking,
  output logic       frame_valid,
  output logic       scan_err,
  output logic       seg_err
);

  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255 || BLINK_FRAMES < 2 || BLINK_FRAMES > 255) begin : g_bad_param
    $error("seg_scan_decoder: SETTLE_CYCLES and BLINK_FRAMES must be in 2..255");
  end

  typedef enum logic [1:0] {SYNC, EXP2, EXP1, EXP0} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [10:0] sync1_q, sync2_q, prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        strobe;

  state_t      state_q, state_d;
  logic [15:0] shadow_bcd_q, shadow_bcd_d;
  logic [3:0]  shadow_blank_q, shadow_blank_d;
  logic [15:0] out_bcd_q, out_bcd_d;
  logic [3:0]  out_blank_q, out_blank_d;
  logic        frame_valid_q, frame_valid_d;
  logic        scan_err_q, scan_err_d;
  logic        seg_err_q, seg_err_d;
  logic        commit;

  logic [3:0]  s_anode;
  logic [6:0]  s_cath;
  logic [1:0]  idx, exp_idx;
  logic        idle, anode_ok;
  logic [5:0]  seg_dec;

  // Returns {valid, blank, bcd[3:0]} for an active-low {g..a} pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] c);
    case (c)
      7'b1000000: return 6'b10_0000;
      7'b1111001: return 6'b10_0001;
      7'b0100100: return 6'b10_0010;
      7'b0110000: return 6'b10_0011;
      7'b0011001: return 6'b10_0100;
      7'b0010010: return 6'b10_0101;
      7'b0000010: return 6'b10_0110;
      7'b1111000: return 6'b10_0111;
      7'b0000000: return 6'b10_1000;
      7'b0010000: return 6'b10_1001;
      7'b1111111: return 6'b11_0000;
      default:    return 6'b00_0000;
    endcase
  endfunction

  // Stability filter: one strobe per settled change of the synchronized sample.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    strobe  = 1'b0;
    if (sync2_q != prev_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == SETTLE_LAST) begin
        strobe  = 1'b1;
        armed_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign s_anode = sync2_q[10:7];
  assign s_cath  = sync2_q[6:0];
  assign seg_dec = decode_seg(s_cath);

  always_comb begin
    idx      = 2'd0;
    idle     = 1'b0;
    anode_ok = 1'b1;
    case (s_anode)
      4'b0111: idx = 2'd3;
      4'b1011: idx = 2'd2;
      4'b1101: idx = 2'd1;
      4'b1110: idx = 2'd0;
      4'b1111: idle = 1'b1;
      default: anode_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (state_q)
      EXP2:    exp_idx = 2'd2;
      EXP1:    exp_idx = 2'd1;
      default: exp_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    shadow_bcd_d   = shadow_bcd_q;
    shadow_blank_d = shadow_blank_q;
    scan_err_d     = 1'b0;
    seg_err_d      = 1'b0;
    commit         = 1'b0;
    if (strobe && !idle) begin
      if (!anode_ok) begin
        scan_err_d = 1'b1;
        state_d    = SYNC;
      end else if (!seg_dec[5]) begin
        seg_err_d = 1'b1;
        state_d   = SYNC;
      end else if (state_q == SYNC) begin
        if (idx == 2'd3) begin
          shadow_bcd_d[15:12] = seg_dec[3:0];
          shadow_blank_d[3]   = seg_dec[4];
          state_d             = EXP2;
        end
      end else if (idx == exp_idx) begin
        shadow_bcd_d[idx*4 +: 4] = seg_dec[3:0];
        shadow_blank_d[idx]      = seg_dec[4];
        case (state_q)
          EXP2:    state_d = EXP1;
          EXP1:    state_d = EXP0;
          default: begin
            state_d = SYNC;
            commit  = 1'b1;
          end
        endcase
      end else if (idx != exp_idx + 2'd1) begin
        // Out-of-order digit; a fresh digit3 restarts the frame immediately.
        scan_err_d = 1'b1;
        if (idx == 2'd3) begin
          shadow_bcd_d[15:12] = seg_dec[3:0];
          shadow_blank_d[3]   = seg_dec[4];
          state_d             = EXP2;
        end else begin
          state_d = SYNC;
        end
      end
    end
  end

  always_comb begin
    out_bcd_d     = out_bcd_q;
    out_blank_d   = out_blank_q;
    frame_valid_d = commit;
    if (commit) begin
      out_bcd_d   = shadow_bcd_d;
      out_blank_d = shadow_blank_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      prev_q         <= '1;
      cnt_q          <= '0;
      armed_q        <= 1'b0;
      state_q        <= SYNC;
      shadow_bcd_q   <= '0;
      shadow_blank_q <= '0;
      out_bcd_q      <= '0;
      out_blank_q    <= 4'b1111;
      frame_valid_q  <= 1'b0;
      scan_err_q     <= 1'b0;
      seg_err_q      <= 1'b0;
    end else begin
      sync1_q        <= {anode, cathode};
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      cnt_q          <= cnt_d;
      armed_q        <= armed_d;
      state_q        <= state_d;
      shadow_bcd_q   <= shadow_bcd_d;
      shadow_blank_q <= shadow_blank_d;
      out_bcd_q      <= out_bcd_d;
      out_blank_q    <= out_blank_d;
      frame_valid_q  <= frame_valid_d;
      scan_err_q     <= scan_err_d;
      seg_err_q      <= seg_err_d;
    end
  end

`ifdef SEG_DECODE_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES);

  logic [3:0][7:0] bcnt_q, bcnt_d;
  logic [3:0]      blinking_q, blinking_d;

  // Per-digit frames since the blank bit last flipped, saturating at BLINK_FRAMES.
  always_comb begin
    bcnt_d     = bcnt_q;
    blinking_d = blinking_q;
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (out_blank_d[i] != out_blank_q[i]) begin
          blinking_d[i] = 1'b1;
          bcnt_d[i]     = '0;
        end else begin
          if (bcnt_q[i] != BLINK_LAST) bcnt_d[i] = bcnt_q[i] + 8'd1;
          if (bcnt_d[i] == BLINK_LAST) blinking_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q     <= '0;
      blinking_q <= '0;
    end else begin
      bcnt_q     <= bcnt_d;
      blinking_q <= blinking_d;
    end
  end

  assign blinking = blinking_q;
`else
  assign blinking = 4'b0000;
`endif

  assign digit3      = out_bcd_q[15:12];
  assign digit2      = out_bcd_q[11:8];
  assign digit1      = out_bcd_q[7:4];
  assign digit0      = out_bcd_q[3:0];
  assign blank       = out_blank_q;
  assign frame_valid = frame_valid_q;
  assign scan_err    = scan_err_q;
  assign seg_err     = seg_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed and randomized scan sequences checked against a frame-level model of the decoder.
module tb_seg_scan_decoder;
  localparam int SETTLE = 4;
  localparam int BLINK  = 8;
  localparam int HOLD   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] anode = 4'hF;
  logic [6:0] cathode = 7'h7F;
  logic [3:0] digit3, digit2, digit1, digit0, blank, blinking;
  logic       frame_valid, scan_err, seg_err;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .anode(anode), .cathode(cathode),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .blank(blank), .blinking(blinking),
    .frame_valid(frame_valid), .scan_err(scan_err), .seg_err(seg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_fv = 0, n_scan = 0, n_seg = 0, n_both = 0;
  int last_fv_cyc = 0, last_scan_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin n_fv++; last_fv_cyc = cyc; end
      if (scan_err) begin n_scan++; last_scan_cyc = cyc; end
      if (seg_err) n_seg++;
      if (scan_err && seg_err) n_both++;
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [6:0] pat(input int v);
    return (v >= 10) ? 7'h7F : seg_tab[v];
  endfunction

  function automatic logic [3:0] an_of(input int i);
    logic [3:0] one;
    one = 4'b0001 << i;
    return ~one;
  endfunction

  // Frame-level reference: expected next digit (-1 = waiting for digit3), shadow and committed values.
  int         m_exp;
  int         sh_bcd [4];
  logic [3:0] sh_blank;
  int         m_dig [4];
  logic [3:0] m_blank, m_blink;
  int         m_since [4];
  bit         m_act [4];
  logic [10:0] cur;

  task automatic model_reset();
    m_exp = -1; sh_blank = 4'h0; m_blank = 4'hF; m_blink = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sh_bcd[i] = 0; m_dig[i] = 0; m_since[i] = 0; m_act[i] = 0;
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < 4; i++) begin
      if (sh_blank[i] != m_blank[i]) begin
        m_act[i] = 1; m_since[i] = 0;
      end else if (m_act[i]) begin
        m_since[i]++;
        if (m_since[i] >= BLINK) m_act[i] = 0;
      end
      m_dig[i] = sh_bcd[i];
`ifdef SEG_DECODE_BLINK_EN
      m_blink[i] = m_act[i];
`else
      m_blink[i] = 1'b0;
`endif
    end
    m_blank = sh_blank;
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] c,
                            output bit fv, output bit se, output bit ge);
    int idx, val;
    bit bl;
    fv = 0; se = 0; ge = 0;
    if (a == 4'hF) return;
    if ($countones(~a) != 1) begin se = 1; m_exp = -1; return; end
    idx = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
    val = -1; bl = 0;
    if (c == 7'h7F) begin val = 0; bl = 1; end
    else for (int k = 0; k < 10; k++) if (seg_tab[k] == c) val = k;
    if (val < 0) begin ge = 1; m_exp = -1; return; end
    if (m_exp < 0) begin
      if (idx == 3) begin sh_bcd[3] = val; sh_blank[3] = bl; m_exp = 2; end
    end else if (idx == m_exp) begin
      sh_bcd[idx] = val; sh_blank[idx] = bl;
      if (idx == 0) begin model_commit(); fv = 1; m_exp = -1; end
      else m_exp--;
    end else if (idx != m_exp + 1) begin
      se = 1;
      if (idx == 3) begin sh_bcd[3] = val; sh_blank[3] = bl; m_exp = 2; end
      else m_exp = -1;
    end
  endtask

  task automatic check_outputs();
    check("digits", {digit3, digit2, digit1, digit0},
          {m_dig[3][3:0], m_dig[2][3:0], m_dig[1][3:0], m_dig[0][3:0]});
    check("blank", blank, m_blank);
    check("blinking", blinking, m_blink);
  endtask

  // lat: 0 = none, 1 = frame_valid latency, 2 = scan_err latency
  task automatic drive(input logic [3:0] a, input logic [6:0] c, input int lat);
    bit efv, ese, ege;
    int f0, s0, g0, t0;
    efv = 0; ese = 0; ege = 0;
    if ({a, c} != cur) model_step(a, c, efv, ese, ege);
    cur = {a, c};
    f0 = n_fv; s0 = n_scan; g0 = n_seg;
    anode = a; cathode = c; t0 = cyc;
    repeat (HOLD) @(posedge clk);
    #1;
    check("frame_valid_pulses", n_fv - f0, 32'(efv));
    check("scan_err_pulses", n_scan - s0, 32'(ese));
    check("seg_err_pulses", n_seg - g0, 32'(ege));
    check("err_overlap", n_both, 0);
    check_outputs();
    if (lat == 1) check("frame_valid_latency", last_fv_cyc - t0, SETTLE + 3);
    if (lat == 2) check("scan_err_latency", last_scan_cyc - t0, SETTLE + 3);
  endtask

  task automatic frame(input int v3, input int v2, input int v1, input int v0);
    drive(an_of(3), pat(v3), 0);
    drive(an_of(2), pat(v2), 0);
    drive(an_of(1), pat(v1), 0);
    drive(an_of(0), pat(v0), 0);
  endtask

  task automatic reset_check();
    check("rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check("rst_blank", blank, 4'hF);
    check("rst_blinking", blinking, 4'h0);
    check("rst_flags", {frame_valid, scan_err, seg_err}, 3'b000);
  endtask

  initial begin
    model_reset();
    cur = {4'hF, 7'h7F};
    repeat (3) @(posedge clk);
    #1;
    reset_check();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean frame 1,2,5,9 with frame_valid latency check
    drive(an_of(3), pat(1), 0);
    drive(an_of(2), pat(2), 0);
    drive(an_of(1), pat(5), 0);
    drive(an_of(0), pat(9), 1);

    // One-cycle cathode glitch during digit1
    drive(an_of(3), pat(7), 0);
    drive(an_of(2), pat(0), 0);
    drive(an_of(1), pat(6), 0);
    cathode = 7'b0000000;
    cur = {anode, 7'b0000000};
    @(posedge clk); #1;
    drive(an_of(1), pat(6), 0);
    drive(an_of(0), pat(4), 0);

    // digit2 skipped
    drive(an_of(3), pat(3), 0);
    drive(an_of(1), pat(3), 2);
    drive(an_of(0), pat(3), 0);
    frame(8, 8, 8, 8);

    // Bad segment pattern on digit2
    drive(an_of(3), pat(2), 0);
    drive(an_of(2), 7'b0101010, 0);
    drive(an_of(1), pat(2), 0);
    drive(an_of(0), pat(2), 0);
    frame(0, 4, 10, 7);

    // Illegal anode, then a partial scan that must not commit
    drive(4'b0011, pat(5), 0);
    drive(an_of(1), pat(5), 0);
    drive(an_of(0), pat(5), 0);

    // Repeat of an accepted digit via idle gap
    drive(an_of(3), pat(6), 0);
    drive(4'hF, 7'h7F, 0);
    drive(an_of(3), pat(6), 0);
    drive(an_of(2), pat(1), 0);
    drive(an_of(1), pat(0), 0);
    drive(an_of(0), pat(3), 0);

    // Reset in the middle of a frame
    drive(an_of(3), pat(9), 0);
    drive(an_of(2), pat(9), 0);
    rst_n = 1'b0;
    anode = 4'hF; cathode = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cur = {4'hF, 7'h7F};
    reset_check();
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(an_of(1), pat(9), 0);
    drive(an_of(0), pat(9), 0);
    frame(2, 0, 2, 6);

    // Digits 3 and 2 blink, then hold steady
    for (int f = 0; f < 12; f++) frame((f % 2) ? 10 : 5, (f % 2) ? 10 : 6, 7, 8);
    for (int f = 0; f < 10; f++) frame(5, 6, 7, 8);

    // Randomized frames with occasional faults
    for (int f = 0; f < 40; f++) begin
      for (int d = 3; d >= 0; d--) begin
        int r;
        logic [3:0] a;
        logic [6:0] c;
        r = $urandom_range(0, 19);
        a = an_of(d);
        c = pat($urandom_range(0, 10));
        if (r == 0) a = 4'($urandom_range(0, 15));
        else if (r == 1) c = 7'($urandom);
        if (r == 2) continue;
        if (r == 3) begin
          drive(a, c, 0);
          drive(4'hF, 7'h7F, 0);
        end
        drive(a, c, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the four-digit multiplexed seven-segment driver. It samples the active-low anode/cathode scan stream and rebuilds the four displayed digits as BCD, one complete frame at a time. It also flags blanked digits, malformed scans and, optionally, blinking digits. It sits in the clock top-level as a readback/self-check monitor and as the bench's scoreboard tap on the display pins.

## Interface
Parameters:
- SETTLE_CYCLES, 4: consecutive identical synchronized samples required before a scan step is accepted (legal range 2..255).
- BLINK_FRAMES, 8: frame window for blink detection (legal range 2..255).

Ports:
- clk  in  1  system clock, the fast board clock; scan inputs are asynchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- anode  in  4  active-low digit enables; 0111 = digit3 (min1), 1011 = digit2, 1101 = digit1, 1110 = digit0 (sec0).
- cathode  in  7  active-low segments {g,f,e,d,c,b,a}.
- digit3, digit2, digit1, digit0  out  4 each  decoded BCD, committed per frame.
- blank  out  4  bit i = digit i was all-segments-off (1111111) in the last committed frame.
- blinking  out  4  bit i = digit i is toggling between blank and visible.
- frame_valid  out  1  one-cycle pulse when outputs are committed.
- scan_err  out  1  one-cycle pulse when the scan order is broken or the anode is illegal.
- seg_err  out  1  one-cycle pulse when an accepted cathode pattern is not a digit or blank.

## Operation
- Input stage: two-flop synchronizer on {anode, cathode}. Stability counter resets whenever the synchronized sample differs from the previous one. When the counter reaches SETTLE_CYCLES-1, it emits a single accept strobe and re-arms only after the next change.
- Anode decode at strobe: exactly one low bit gives the digit index. 1111 = idle, ignored with no state change. Two or more low bits give scan_err and FSM to SYNC.
- Cathode decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111 (BCD captured as 0, blank bit set). Any other pattern gives seg_err, frame discarded, FSM to SYNC.
- Each accepted digit is written to a shadow register. Outputs update only at frame commit.
- FSM states and transitions:
  - SYNC: digit3 goes to EXP2; any other digit stays in SYNC, no error.
  - EXP2 expects digit2, then EXP1 expects digit1, then EXP0 expects digit0.
  - Expected digit: advance.
  - Repeat of the digit just accepted: ignore.
  - digit0 in EXP0: commit shadow to outputs, pulse frame_valid, go to SYNC.
  - Any other digit: scan_err. If that digit is digit3, go to EXP2 with it captured; otherwise go to SYNC.
- Blink detection: see Configuration.
- Reset mid-frame: all state returns to reset values immediately. The first frame_valid requires a full digit3..digit0 scan after release.

## Timing
- Reset values: digit3..digit0 = 0, blank = 1111, blinking = 0000, frame_valid = 0, scan_err = 0, seg_err = 0, FSM = SYNC, shadow = 0, counters = 0.
- Input change to accept strobe: 2 + SETTLE_CYCLES clk cycles.
- Error pulses are registered, one cycle after the strobe.
- digit0 strobe to frame_valid and updated outputs: 1 cycle, same edge for both.
- Changes shorter than SETTLE_CYCLES samples are filtered and never accepted.
- scan_err and seg_err never assert together. seg_err takes priority when the anode is legal and the pattern is bad.

## Configuration
- SEG_DECODE_BLINK_EN defined:
  - Per digit, a frame counter saturating at BLINK_FRAMES.
  - At each commit, if the blank bit differs from its previous committed value, blinking[i] is set to 1 and the counter is cleared. Otherwise the counter increments.
  - When the counter reaches BLINK_FRAMES, blinking[i] is cleared.
- SEG_DECODE_BLINK_EN not defined: no counters are built and blinking is tied to 0000.

## Test plan
- Reset release, then clean scan 3,2,1,0 with 1,2,5,9 patterns (each held 20 clk) -> one frame_valid; digits 1,2,5,9; blank 0000; no errors.
- 1-cycle cathode glitch to 0000000 during digit1 -> filtered; committed digits unchanged.
- Scan 3,1,0 (digit2 skipped) -> scan_err one cycle after the digit1 strobe; no frame_valid until the next full scan.
- Cathode 0101010 on digit2 -> seg_err; frame discarded; next clean frame commits.
- Anode 0011 -> scan_err; FSM in SYNC.
- With SEG_DECODE_BLINK_EN, digits 3 and 2 alternate blank/visible every frame -> blinking = 1100. After the toggling stops for 8 frames -> blinking = 0000. Without the macro, blinking stays 0000.
